// File: rtl/mem_wb_if.sv
// MEM/WB boundary bundle: MEM-stage inputs, hazard controls and registered writeback outputs.
// The master drives the MEM side and controls; the slave (the pipe) drives the WB side.
interface mem_wb_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  stall_i;
  logic                  flush_i;
  logic                  cnt_clr_i;
  logic                  valid_m;
  logic [DATA_W-1:0]     alu_res;
  logic [DATA_W-1:0]     mem_data;
  logic [REG_ADDR_W-1:0] writereg;
  logic                  RegWrite_m;
  logic                  MemtoReg_m;
  logic [DATA_W-1:0]     alu_r;
  logic [DATA_W-1:0]     memory;
  logic [REG_ADDR_W-1:0] dest;
  logic                  RegWrite_w;
  logic                  MemtoReg_w;
  logic                  valid_w;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_we;
  logic [CNT_W-1:0]      retired_cnt;

  modport master (
    output stall_i, flush_i, cnt_clr_i, valid_m, alu_res, mem_data, writereg, RegWrite_m, MemtoReg_m,
    input  alu_r, memory, dest, RegWrite_w, MemtoReg_w, valid_w, wb_data, wb_we, retired_cnt
  );

  modport slave (
    input  stall_i, flush_i, cnt_clr_i, valid_m, alu_res, mem_data, writereg, RegWrite_m, MemtoReg_m,
    output alu_r, memory, dest, RegWrite_w, MemtoReg_w, valid_w, wb_data, wb_we, retired_cnt
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register chain (STAGES deep, 1..4) with stall/flush, writeback mux,
// gated register-file write enable and a retired-instruction counter.
module mem_wb_pipe #(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int STAGES         = 1,
  parameter int CNT_W          = 32,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_wb_if.slave  bus
);
  localparam int LAST = STAGES - 1;

  logic [DATA_W-1:0]     stg_alu_r  [STAGES];
  logic [DATA_W-1:0]     stg_mem_r  [STAGES];
  logic [REG_ADDR_W-1:0] stg_dest_r [STAGES];
  logic                  stg_rw_r   [STAGES];
  logic                  stg_mtr_r  [STAGES];
  logic                  stg_vld_r  [STAGES];
  logic [CNT_W-1:0]      cnt_r;
  logic                  retire_s;
  logic                  dest_ok_s;

  // Stage chain: flush clears only control bits so data/dest stay observable; stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_alu_r[k]  <= {DATA_W{1'b0}};
        stg_mem_r[k]  <= {DATA_W{1'b0}};
        stg_dest_r[k] <= {REG_ADDR_W{1'b0}};
        stg_rw_r[k]   <= 1'b0;
        stg_mtr_r[k]  <= 1'b0;
        stg_vld_r[k]  <= 1'b0;
      end
    end else if (bus.flush_i) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_rw_r[k]  <= 1'b0;
        stg_mtr_r[k] <= 1'b0;
        stg_vld_r[k] <= 1'b0;
      end
    end else if (!bus.stall_i) begin
      stg_alu_r[0]  <= bus.alu_res;
      stg_mem_r[0]  <= bus.mem_data;
      stg_dest_r[0] <= bus.writereg;
      stg_rw_r[0]   <= bus.valid_m & bus.RegWrite_m;
      stg_mtr_r[0]  <= bus.valid_m & bus.MemtoReg_m;
      stg_vld_r[0]  <= bus.valid_m;
      for (int k = 1; k < STAGES; k++) begin
        stg_alu_r[k]  <= stg_alu_r[k-1];
        stg_mem_r[k]  <= stg_mem_r[k-1];
        stg_dest_r[k] <= stg_dest_r[k-1];
        stg_rw_r[k]   <= stg_rw_r[k-1];
        stg_mtr_r[k]  <= stg_mtr_r[k-1];
        stg_vld_r[k]  <= stg_vld_r[k-1];
      end
    end else begin
      stg_vld_r[0] <= stg_vld_r[0];
    end
  end

  assign retire_s = stg_vld_r[LAST] & ~bus.stall_i & ~bus.flush_i;

  // Retired-instruction counter; clear wins over a simultaneous retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (bus.cnt_clr_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Writeback select and zero-register guard from the last stage.
  always_comb begin
    dest_ok_s = 1'b1;
    if (ZERO_REG_GUARD != 0) begin
      dest_ok_s = (stg_dest_r[LAST] != {REG_ADDR_W{1'b0}});
    end else begin
      dest_ok_s = 1'b1;
    end
  end

  assign bus.alu_r       = stg_alu_r[LAST];
  assign bus.memory      = stg_mem_r[LAST];
  assign bus.dest        = stg_dest_r[LAST];
  assign bus.RegWrite_w  = stg_rw_r[LAST];
  assign bus.MemtoReg_w  = stg_mtr_r[LAST];
  assign bus.valid_w     = stg_vld_r[LAST];
  assign bus.wb_data     = stg_mtr_r[LAST] ? stg_mem_r[LAST] : stg_alu_r[LAST];
  assign bus.wb_we       = stg_vld_r[LAST] & stg_rw_r[LAST] & dest_ok_s;
  assign bus.retired_cnt = cnt_r;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: four configurations share one stimulus stream and are compared
// against a queue-based transaction model, plus directed constant checks.
module tb_mem_wb_pipe;
  localparam int NCFG = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_i, flush_i, cnt_clr_i, valid_m, rw_m, mtr_m;
  logic [31:0] alu_res, mem_data;
  logic [4:0]  writereg;

  logic [NCFG-1:0][31:0] o_alu, o_mem, o_wbd, o_cnt;
  logic [NCFG-1:0][4:0]  o_dest;
  logic [NCFG-1:0]       o_rw, o_mtr, o_v, o_we;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
    localparam int GD = (g == 2) ? 0 : 1;
    localparam int CW = (g == 1 || g == 3) ? 4 : 32;

    mem_wb_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CW)) bus ();

    assign bus.stall_i    = stall_i;
    assign bus.flush_i    = flush_i;
    assign bus.cnt_clr_i  = cnt_clr_i;
    assign bus.valid_m    = valid_m;
    assign bus.alu_res    = alu_res;
    assign bus.mem_data   = mem_data;
    assign bus.writereg   = writereg;
    assign bus.RegWrite_m = rw_m;
    assign bus.MemtoReg_m = mtr_m;

    mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .STAGES(ST), .CNT_W(CW), .ZERO_REG_GUARD(GD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    assign o_alu[g]  = bus.alu_r;
    assign o_mem[g]  = bus.memory;
    assign o_wbd[g]  = bus.wb_data;
    assign o_cnt[g]  = 32'(bus.retired_cnt);
    assign o_dest[g] = bus.dest;
    assign o_rw[g]   = bus.RegWrite_w;
    assign o_mtr[g]  = bus.MemtoReg_w;
    assign o_v[g]    = bus.valid_w;
    assign o_we[g]   = bus.wb_we;
  end

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  dest;
    logic        v;
    logic        rw;
    logic        mtr;
  } txn_t;

  txn_t        pipe [NCFG][$];
  logic [31:0] mcnt [NCFG];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int st_of(int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
  endfunction
  function automatic logic [31:0] mask_of(int g);
    return (g == 1 || g == 3) ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txn_t z;
    z = '{alu: 32'h0, mem: 32'h0, dest: 5'h0, v: 1'b0, rw: 1'b0, mtr: 1'b0};
    for (int g = 0; g < NCFG; g++) begin
      pipe[g].delete();
      for (int i = 0; i < st_of(g); i++) pipe[g].push_back(z);
      mcnt[g] = 32'h0;
    end
  endtask

  // Applies one clock edge worth of behaviour to every configuration's transaction queue.
  task automatic model_edge();
    txn_t t;
    txn_t n;
    for (int g = 0; g < NCFG; g++) begin
      t = pipe[g][pipe[g].size()-1];
      if (cnt_clr_i) mcnt[g] = 32'h0;
      else if (t.v && !stall_i && !flush_i) mcnt[g] = (mcnt[g] + 32'd1) & mask_of(g);
      if (flush_i) begin
        for (int i = 0; i < pipe[g].size(); i++) begin
          t = pipe[g][i];
          t.v = 1'b0; t.rw = 1'b0; t.mtr = 1'b0;
          pipe[g][i] = t;
        end
      end else if (!stall_i) begin
        n = '{alu: alu_res, mem: mem_data, dest: writereg, v: valid_m,
              rw: valid_m & rw_m, mtr: valid_m & mtr_m};
        pipe[g].push_front(n);
        void'(pipe[g].pop_back());
      end
    end
  endtask

  task automatic check_all();
    txn_t t;
    logic we;
    for (int g = 0; g < NCFG; g++) begin
      t  = pipe[g][pipe[g].size()-1];
      we = t.v & t.rw & ((g == 2) ? 1'b1 : (t.dest != 5'd0));
      check($sformatf("g%0d alu_r", g),    64'(o_alu[g]),  64'(t.alu));
      check($sformatf("g%0d memory", g),   64'(o_mem[g]),  64'(t.mem));
      check($sformatf("g%0d dest", g),     64'(o_dest[g]), 64'(t.dest));
      check($sformatf("g%0d valid_w", g),  64'(o_v[g]),    64'(t.v));
      check($sformatf("g%0d RegWrite", g), 64'(o_rw[g]),   64'(t.rw));
      check($sformatf("g%0d MemtoReg", g), 64'(o_mtr[g]),  64'(t.mtr));
      check($sformatf("g%0d wb_data", g),  64'(o_wbd[g]),  64'(t.mtr ? t.mem : t.alu));
      check($sformatf("g%0d wb_we", g),    64'(o_we[g]),   64'(we));
      check($sformatf("g%0d cnt", g),      64'(o_cnt[g]),  64'(mcnt[g]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] m, input logic [4:0] wr,
                       input logic rw, input logic mt, input logic st, input logic fl, input logic clr);
    valid_m = v; alu_res = a; mem_data = m; writereg = wr; rw_m = rw; mtr_m = mt;
    stall_i = st; flush_i = fl; cnt_clr_i = clr;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("%s g%0d alu", tag, g),  64'(o_alu[g]),  64'h0);
      check($sformatf("%s g%0d mem", tag, g),  64'(o_mem[g]),  64'h0);
      check($sformatf("%s g%0d dest", tag, g), 64'(o_dest[g]), 64'h0);
      check($sformatf("%s g%0d v", tag, g),    64'(o_v[g]),    64'h0);
      check($sformatf("%s g%0d we", tag, g),   64'(o_we[g]),   64'h0);
      check($sformatf("%s g%0d cnt", tag, g),  64'(o_cnt[g]),  64'h0);
    end
  endtask

  initial begin
    bubble();
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Simple ALU writeback
    drive(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("t1 wb_data", 64'(o_wbd[0]), 64'h1234);
    check("t1 dest",    64'(o_dest[0]), 64'd5);
    check("t1 wb_we",   64'(o_we[0]), 64'd1);
    bubble();
    step();
    check("t1 cnt", 64'(o_cnt[0]), 64'd1);

    // Loads, zero-register guard on and off
    drive(1'b1, 32'h55, 32'hDEADBEEF, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("t2 wb_data", 64'(o_wbd[0]), 64'hDEADBEEF);
    check("t2 wb_we",   64'(o_we[0]), 64'd1);
    drive(1'b1, 32'h55, 32'hDEADBEEF, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("t2 guard we", 64'(o_we[0]), 64'd0);
    bubble();
    step();
    check("t2 noguard dest", 64'(o_dest[2]), 64'd0);
    check("t2 noguard we",   64'(o_we[2]), 64'd1);

    // Back-to-back with a 2-cycle stall mid-stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 32'h0, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'hBAD, 32'h0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      bubble();
      step();
    end

    // Flush and stall together with entries in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), 32'h0, 5'(i + 9), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'hC3, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("t4 valid_w", 64'(o_v[1]),  64'd0);
    check("t4 RegWr",   64'(o_rw[1]), 64'd0);
    check("t4 wb_we",   64'(o_we[1]), 64'd0);

    // Counter wrap on 4-bit counters, then clear on a retire edge
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'(i), 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      bubble();
      step();
    end
    check("t5 wrap g1", 64'(o_cnt[1]), 64'd1);
    check("t5 wrap g3", 64'(o_cnt[3]), 64'd1);
    check("t5 full g0", 64'(o_cnt[0]), 64'd17);
    drive(1'b1, 32'h77, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("t5 clr on retire", 64'(o_cnt[0]), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(99, 0) < 70), $urandom(), $urandom(),
            ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
            1'($urandom()), 1'($urandom()),
            ($urandom_range(99, 0) < 20), ($urandom_range(99, 0) < 10), ($urandom_range(99, 0) < 5));
      step();
    end

    // Asynchronous reset between edges with a live entry at the output
    drive(1'b1, 32'hFEED, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("t6 pre valid", 64'(o_v[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async");
    @(negedge clk);
    rst_n = 1'b1;
    bubble();
    step();
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom()), $urandom(), $urandom(), 5'($urandom()), 1'($urandom()), 1'($urandom()),
            ($urandom_range(99, 0) < 15), ($urandom_range(99, 0) < 8), 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
